// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: turns a 3-bit {B,G,R} colour code into three PWM LED drives
// with programmable brightness. On a colour or brightness change it
// crossfades linearly, one duty LSB per step event, instead of hard-switching.
module rgb_pwm_fader #(
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE   = 390,
    parameter int FADE_DIV   = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          bgr_in,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic                enable,
    output logic                led_b,
    output logic                led_g,
    output logic                led_r,
    output logic                fade_busy
);

    localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DIV_W   = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(FADE_DIV - 1);
    // The counter stops one short of all-ones so that a full-scale duty
    // keeps the output permanently on.
    localparam logic [PWM_BITS-1:0] CNT_LAST   = PWM_BITS'((1 << PWM_BITS) - 2);

    typedef enum logic {
        STEADY = 1'b0,
        FADE   = 1'b1
    } state_t;

    state_t              state_reg;
    state_t              state_next;

    logic [2:0]          bgr_meta_reg;
    logic [2:0]          bgr_s_reg;
    logic [PRESC_W-1:0]  presc_reg;
    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic [DIV_W-1:0]    fade_div_reg;
    logic                tick;
    logic                pb;
    logic                step_evt;

    // Channel index: 0 = red, 1 = green, 2 = blue (matches bgr bit order).
    logic [PWM_BITS-1:0] duty_reg  [3];
    logic [PWM_BITS-1:0] duty_next [3];
    logic [PWM_BITS-1:0] tgt       [3];
    logic [2:0]          differ;
    logic [2:0]          settled;
    logic [2:0]          pwm_raw;
    logic [2:0]          led_reg;

    // Two-flop synchronizer for the colour code, which may be asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bgr_meta_reg <= '0;
            bgr_s_reg    <= '0;
        end else begin
            bgr_meta_reg <= bgr_in;
            bgr_s_reg    <= bgr_meta_reg;
        end
    end

    assign tick     = (presc_reg == PRESC_LAST);
    assign pb       = tick && (pwm_cnt_reg == CNT_LAST);
    assign step_evt = pb && (state_reg == FADE) && (fade_div_reg == DIV_LAST);

    // Prescaler: divides clk down to the PWM count rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    // PWM counter: 0..2^PWM_BITS-2, wrap marks the period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_reg <= '0;
        end else if (tick) begin
            pwm_cnt_reg <= (pwm_cnt_reg == CNT_LAST) ? '0 : pwm_cnt_reg + 1'b1;
        end
    end

    // Fade divider: counts period boundaries while fading; held at 0 otherwise
    // so every fade entry starts a fresh FADE_DIV-period interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fade_div_reg <= '0;
        end else if (!enable || state_reg == STEADY) begin
            fade_div_reg <= '0;
        end else if (pb) begin
            fade_div_reg <= (fade_div_reg == DIV_LAST) ? '0 : fade_div_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            // Targets are only acted on at pb, so they never glitch mid-period.
            assign tgt[gi]     = bgr_s_reg[gi] ? brightness : '0;
            assign differ[gi]  = (duty_reg[gi] != tgt[gi]);
            assign settled[gi] = (duty_next[gi] == tgt[gi]);
            assign pwm_raw[gi] = (pwm_cnt_reg < duty_reg[gi]);

            // One-LSB move toward the target; a channel already there holds.
            always_comb begin
                duty_next[gi] = duty_reg[gi];
                if (duty_reg[gi] < tgt[gi]) begin
                    duty_next[gi] = duty_reg[gi] + 1'b1;
                end else if (duty_reg[gi] > tgt[gi]) begin
                    duty_next[gi] = duty_reg[gi] - 1'b1;
                end
            end

            // Duty register: cleared while disabled, stepped on step events.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    duty_reg[gi] <= '0;
                end else if (!enable) begin
                    duty_reg[gi] <= '0;
                end else if (step_evt) begin
                    duty_reg[gi] <= duty_next[gi];
                end
            end

            // Registered LED drive with polarity and enable gating.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    led_reg[gi] <= ACTIVE_LOW;
                end else begin
                    led_reg[gi] <= enable ? (pwm_raw[gi] ^ ACTIVE_LOW) : ACTIVE_LOW;
                end
            end
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= STEADY;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: decisions are taken only at period boundaries.
    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = STEADY;
        end else if (pb) begin
            case (state_reg)
                STEADY:  if (|differ) state_next = FADE;
                FADE:    if (step_evt && (&settled)) state_next = STEADY;
                default: state_next = STEADY;
            endcase
        end
    end

    // FSM outputs and LED pin mapping.
    always_comb begin
        fade_busy = (state_reg == FADE);
        led_r     = led_reg[0];
        led_g     = led_reg[1];
        led_b     = led_reg[2];
    end

endmodule
